// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, arbiter state encoding and frame timing helper
package uart_pkg;

  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_SEND  = 2'd3
  } arb_state_e;

  function automatic int frame_clocks(input int clocks_per_baud);
    return FRAME_BITS * clocks_per_baud;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serializer without reset or busy flag; write_i starts a new frame
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic       clk_i,
  input  logic       write_i,
  input  logic [7:0] data_i,
  output logic       tx_o
);

  localparam int BW = $clog2(CLOCKS_PER_BAUD + 1);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLOCKS_PER_BAUD - 1);

  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bits_q, bits_d;
  logic [9:0]    shift_q, shift_d;

  always_comb begin
    baud_d  = baud_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    if (write_i) begin
      shift_d = {1'b1, data_i, 1'b0};
      bits_d  = 4'(FRAME_BITS);
      baud_d  = BAUD_LOAD;
    end else if (bits_q != 4'd0) begin
      if (baud_q == '0) begin
        shift_d = {1'b1, shift_q[9:1]};
        bits_d  = bits_q - 4'd1;
        baud_d  = BAUD_LOAD;
      end else begin
        baud_d  = baud_q - BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    baud_q  <= baud_d;
    bits_q  <= bits_d;
    shift_q <= shift_d;
  end

  assign tx_o = (bits_q != 4'd0) ? shift_q[0] : 1'b1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among NUM_REQ byte requesters
// Optional packet locking: UART_ARB_LOCK_EN
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int CLOCKS_PER_BAUD = 104
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [8*NUM_REQ-1:0]       req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       busy_o,
  output logic                       tx_o
);

  localparam int IW           = $clog2(NUM_REQ);
  localparam int FRAME_CLOCKS = frame_clocks(CLOCKS_PER_BAUD);
  localparam int CW           = $clog2(FRAME_CLOCKS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CLOCKS - 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0] cand_valid;
  logic [IW:0]   pick;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          write;
  logic          tx_raw;

  // First valid at or after ptr, wrapping; MSB of the result flags a hit.
  function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                          input logic [IW-1:0] ptr);
    logic [IW:0] res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQ;
      if (valid[idx]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

`ifdef UART_ARB_LOCK_EN
  logic lock_q, lock_d;
  assign cand_valid = lock_q ? (req_valid_i & (NUM_REQ'(1) << grant_q)) : req_valid_i;
`else
  logic unused_last;
  assign unused_last = ^req_last_i;
  assign cand_valid  = req_valid_i;
`endif

  assign pick    = rr_pick(cand_valid, ptr_q);
  assign hit     = pick[IW];
  assign hit_idx = pick[IW-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_FLUSH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef UART_ARB_LOCK_EN
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_FLUSH, ST_SEND: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_IDLE: begin
        if (hit) begin
          state_d = ST_LOAD;
          data_d  = req_data_i[{hit_idx, 3'b000} +: 8];
          grant_d = hit_idx;
          ptr_d   = (hit_idx == IW'(NUM_REQ - 1)) ? '0 : hit_idx + IW'(1);
`ifdef UART_ARB_LOCK_EN
          lock_d  = ~req_last_i[hit_idx];
`endif
        end
      end
      ST_LOAD: begin
        state_d = ST_SEND;
        cnt_d   = CNT_LOAD;
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == ST_IDLE && hit) req_ready_o = NUM_REQ'(1) << hit_idx;
    busy_o = (state_q != ST_IDLE);
    write  = (state_q == ST_LOAD);
  end

  // Counter resets pre-loaded so FLUSH lasts exactly one frame time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= CNT_LOAD;
      data_q  <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
`ifdef UART_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_uart_tx (
    .clk_i  (clk_i),
    .write_i(write),
    .data_i (data_q),
    .tx_o   (tx_raw)
  );

  assign grant_o = grant_q;
  assign tx_o    = rst_ni ? tx_raw : 1'b1;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 104;
  localparam int FC  = 10 * CPB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] valid;
  logic [8*NR-1:0] data;
  logic [NR-1:0] last;
  logic [NR-1:0] req_ready_o;
  logic [1:0]    grant_o;
  logic          busy_o;
  logic          tx_o;

  uart_tx_arbiter #(.NUM_REQ(NR), .CLOCKS_PER_BAUD(CPB)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_valid_i(valid),
    .req_data_i (data),
    .req_last_i (last),
    .req_ready_o(req_ready_o),
    .grant_o    (grant_o),
    .busy_o     (busy_o),
    .tx_o       (tx_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  int       acc_idx[$];
  int       acc_cyc[$];
  logic [7:0] rx_q[$];
  bit       rx_ok[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept monitor: every ready must be one-hot and backed by a valid.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && req_ready_o != '0) begin
      tests++;
      assert ($onehot(req_ready_o) && ((req_ready_o & ~valid) == '0)) else begin
        fails++;
        $error("FAIL ready_onehot: observed %0h expected one-hot within valid %0h", req_ready_o, valid);
      end
      for (int i = 0; i < NR; i++)
        if (req_ready_o[i]) begin
          acc_idx.push_back(i);
          acc_cyc.push_back(cyc);
        end
    end
  end

  // Line receiver sampling each bit at its centre.
  bit         rx_on = 1'b0;
  int         rx_cnt, rx_bit;
  logic [9:0] rx_sh;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) rx_on = 1'b0;
    else if (!rx_on) begin
      if (tx_o === 1'b0) begin
        rx_on = 1'b1; rx_cnt = CPB / 2; rx_bit = 0;
      end
    end else begin
      rx_cnt--;
      if (rx_cnt == 0) begin
        rx_sh[rx_bit] = tx_o;
        rx_bit++;
        rx_cnt = CPB;
        if (rx_bit == 10) begin
          rx_on = 1'b0;
          rx_q.push_back(rx_sh[8:1]);
          rx_ok.push_back(rx_sh[0] == 1'b0 && rx_sh[9] == 1'b1);
        end
      end
    end
  end

  function automatic int acc_at(input int i);
    return (i < acc_idx.size()) ? acc_idx[i] : -1;
  endfunction
  function automatic int cyc_at(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction
  function automatic int rx_at(input int i);
    return (i < rx_q.size()) ? int'(rx_q[i]) : -1;
  endfunction
  function automatic int ok_at(input int i);
    return (i < rx_ok.size()) ? int'(rx_ok[i]) : -1;
  endfunction

  task automatic clear_logs();
    acc_idx.delete(); acc_cyc.delete(); rx_q.delete(); rx_ok.delete();
  endtask

  task automatic wait_acc(input int n, input string tag);
    int k = 0;
    while (acc_idx.size() < n && k < 8000) begin @(negedge clk); k++; end
    check(tag, 32'(acc_idx.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < 3000) begin @(negedge clk); k++; end
    check(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    @(negedge clk);
    while (busy_o && k < 3000) begin @(negedge clk); k++; end
    check(tag, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int busy_n, busy_last, tx_low, k, t, idx1;
    bit adv;
    int exp_rr[5];
    logic [7:0] exp_rb[5];
    logic [7:0] b1[3];
    int exp_li[4];
    logic [7:0] exp_lb[4];

    rst_n = 1'b0; valid = '0; data = '0; last = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy_o), 32'd1);
    check("rst_tx",    32'(tx_o), 32'd1);
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_grant", 32'(grant_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Flush after reset
    busy_n = 0; busy_last = -1; tx_low = 0;
    for (int i = 0; i < 2 * FC; i++) begin
      @(negedge clk);
      if (busy_o) begin busy_n++; busy_last = i; end
      if (tx_o !== 1'b1) tx_low++;
    end
    check("flush_busy_cycles", 32'(busy_n), 32'd1040);
    check("flush_busy_last",   32'(busy_last), 32'd1039);
    check("flush_tx_idle",     32'(tx_low), 32'd0);
    check("flush_no_accept",   32'(acc_idx.size()), 32'd0);

    // All four requesters valid: rotating order and back-to-back period
    clear_logs();
    exp_rr = '{0, 1, 2, 3, 0};
    exp_rb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    @(posedge clk); #1 valid = 4'hF; data = 32'h13121110; last = 4'hF;
    wait_acc(5, "rr_accept_timeout");
    @(posedge clk); #1 valid = '0;
    wait_rx(5, "rr_rx_timeout");
    wait_idle("rr_idle_timeout");
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_idx%0d", i),  32'(acc_at(i)), 32'(exp_rr[i]));
      check($sformatf("rr_byte%0d", i), 32'(rx_at(i)),  32'(exp_rb[i]));
      check($sformatf("rr_frame%0d", i), 32'(ok_at(i)), 32'd1);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_period%0d", i), 32'(cyc_at(i + 1) - cyc_at(i)), 32'd1042);

    // Single byte 0x41 from requester 2
    clear_logs();
    @(posedge clk); #1 valid = 4'b0100; data = 32'h00410000;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready_o[2] && k < 3000);
    check("one_ready", 32'(req_ready_o), 32'h4);
    t = cyc;
    @(posedge clk); #1 valid = '0;
    repeat (1041) @(negedge clk);
    check("one_send_end_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("one_idle_at_t1042", 32'(busy_o), 32'd0);
    check("one_grant",   32'(grant_o), 32'd2);
    check("one_accepts", 32'(acc_idx.size()), 32'd1);
    check("one_byte",    32'(rx_at(0)), 32'h41);
    check("one_frame",   32'(ok_at(0)), 32'd1);

    // Reset in the middle of requester 1's frame
    clear_logs();
    @(posedge clk); #1 valid = 4'b0010; data = 32'h0000FF00;
    wait_acc(1, "mid_accept_timeout");
    @(posedge clk); #1 valid = '0;
    repeat (300) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    valid = 4'b1001; data = 32'h7700003C; last = 4'hF;
    @(negedge clk);
    check("mid_rst_tx",    32'(tx_o), 32'd1);
    check("mid_rst_busy",  32'(busy_o), 32'd1);
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    check("mid_rst_grant", 32'(grant_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rx_q.delete(); rx_ok.delete();
    busy_n = 0;
    for (int i = 0; i < 2 * FC; i++) begin
      @(negedge clk);
      if (!busy_o) break;
      busy_n++;
    end
    check("mid_flush_cycles", 32'(busy_n), 32'd1040);
    check("mid_restart_ready", 32'(req_ready_o), 32'h1);
    @(posedge clk); #1 valid = '0;
    wait_rx(1, "mid_rx_timeout");
    wait_idle("mid_idle_timeout");
    check("mid_accepts", 32'(acc_idx.size()), 32'd2);
    check("mid_restart_idx", 32'(acc_at(1)), 32'd0);
    check("mid_byte", 32'(rx_at(0)), 32'h3C);

    // Three-byte packet from requester 1 against continuously valid requester 0
    clear_logs();
    b1 = '{8'hA1, 8'hA2, 8'hA3};
`ifdef UART_ARB_LOCK_EN
    exp_li = '{1, 1, 1, 0};
    exp_lb = '{8'hA1, 8'hA2, 8'hA3, 8'hB0};
`else
    exp_li = '{1, 0, 1, 0};
    exp_lb = '{8'hA1, 8'hB0, 8'hA2, 8'hB0};
`endif
    idx1 = 0;
    @(posedge clk); #1 valid = 4'b0011; data = {16'h0000, b1[0], 8'hB0}; last = 4'b0001;
    k = 0;
    while (acc_idx.size() < 4 && k < 8000) begin
      @(negedge clk);
      adv = req_ready_o[1];
      @(posedge clk); #1;
      k++;
      if (adv) begin
        idx1++;
        if (idx1 >= 3) valid[1] = 1'b0;
        else begin
          data[15:8] = b1[idx1];
          last[1]    = (idx1 == 2);
        end
      end
    end
    check("pkt_accept_timeout", 32'(acc_idx.size() >= 4), 32'd1);
    valid = '0;
    wait_rx(4, "pkt_rx_timeout");
    wait_idle("pkt_idle_timeout");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pkt_idx%0d", i),  32'(acc_at(i)), 32'(exp_li[i]));
      check($sformatf("pkt_byte%0d", i), 32'(rx_at(i)),  32'(exp_lb[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
